xif_copro_bitmanip_unit: RTL and testbench
==========================================

Name: xif_copro_bitmanip_unit

Overview:
- Parametrised, pipelined bit-manipulation execution unit for the XIF coprocessor.
- Generalises the two-op NONE/BITREV scheme to eight operations, configurable data width and configurable pipeline depth.
- Sits between the coprocessor decoder/operand stage and the result stage.
- Carries the coprocessor tag (id, rd, rd_is_copro) alongside the data, with valid/ready backpressure and a global kill.

Parameters:
- WIDTH, 32, operand/result width; multiple of 8, range 8..64.
- ID_WIDTH, 4, instruction id width; matches X_ID_WIDTH.
- NUM_STAGES, 2, pipeline register stages, range 1..4.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- in_valid_i  in  1  operation valid.
- in_ready_o  out  1  unit accepts operation.
- op_i  in  3  operation: 0 NONE, 1 BITREV, 2 BSWAP, 3 POPCNT, 4 CLZ, 5 CTZ, 6 ROL, 7 ROR.
- rs1_i  in  WIDTH  operand A.
- rs2_i  in  WIDTH  operand B; only used as shift amount.
- id_i  in  ID_WIDTH  instruction id.
- rd_i  in  5  destination register.
- rd_is_copro_i  in  1  destination is a coprocessor register.
- kill_i  in  1  flush all in-flight operations.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  result consumed.
- out_data_o  out  WIDTH  result.
- out_id_o  out  ID_WIDTH  id of result.
- out_rd_o  out  5  destination register of result.
- out_rd_is_copro_o  out  1  tag passthrough.
- busy_o  out  1  any stage holds a valid entry.
- op_count_o  out  32  retired-result counter (optional feature).
- stall_count_o  out  32  output-stall cycle counter (optional feature).

Behaviour:
- Reset: all stage valid bits 0, all data/tag registers 0. Hence out_valid_o=0, out_data_o=0, out_id_o=0, out_rd_o=0, out_rd_is_copro_o=0, busy_o=0, counters 0. Reset mid-operation drops every in-flight entry; none is ever emitted.
- Compute: result is computed combinationally from rs1_i/rs2_i/op_i and registered into stage 0. Stages 1..NUM_STAGES-1 carry data+tag unchanged. Output = last stage.
- Operations:
  - NONE: rs1 passthrough.
  - BITREV: bit i -> bit WIDTH-1-i.
  - BSWAP: byte order reversed.
  - POPCNT: count of ones, zero-extended.
  - CLZ: leading zeros; rs1=0 gives WIDTH.
  - CTZ: trailing zeros; rs1=0 gives WIDTH.
  - ROL/ROR: rotate by rs2[$clog2(WIDTH)-1:0], i.e. amount modulo WIDTH.
- Handshake: input accepted on in_valid_i && in_ready_o. Output retired on out_valid_o && out_ready_i. out_valid_o and all out_* signals stay stable while out_valid_o && !out_ready_i.
- Elastic pipeline: stage k loads when it is empty or advancing. The last stage advances on out_ready_i. in_ready_o = !kill_i && (stage0 empty || stage0 advancing); combinational from out_ready_i.
- Throughput and latency: one op/cycle sustained. Latency NUM_STAGES cycles (accept at edge n -> out_valid_o high after edge n+NUM_STAGES-1... i.e. visible NUM_STAGES cycles after acceptance cycle). Results leave in acceptance order.
- Capacity: NUM_STAGES entries. With out_ready_i held low, exactly NUM_STAGES ops are accepted, then in_ready_o=0.
- Kill: on a cycle with kill_i=1, in_ready_o=0 and no input is accepted. All valid bits clear at the next edge. An output handshake in the same cycle as kill still counts as retired.
- busy_o = OR of all stage valid bits.

Optional Feature:
- Macro XIF_COPRO_BITMANIP_STATS_EN.
- Defined:
  - op_count_o increments on each output handshake.
  - stall_count_o increments on each cycle with out_valid_o && !out_ready_i.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
  - kill_i does not clear them.
- Undefined: both ports are present and tied to 0; no counter flops are built.

Test Plan:
- Defaults, out_ready_i=1: BITREV 0x00000001 -> 0x80000000; BSWAP 0x11223344 -> 0x44332211; each out_valid_o exactly 2 cycles after acceptance, id/rd echoed.
- POPCNT 0xF0F0F0F0 -> 16. CLZ 0x00000000 -> 32. CTZ 0x80000000 -> 31. CLZ 0x00010000 -> 15.
- ROL 0x80000001 by rs2=33 -> 0x00000003. ROR 0x00000003 by rs2=1 -> 0x80000001. NONE 0xDEADBEEF -> 0xDEADBEEF.
- Back-to-back stream of 8 ops with ids 0..7, out_ready_i toggling every other cycle -> all 8 emitted in id order, none lost or duplicated, outputs stable while stalled; with STATS_EN, op_count_o=8 and stall_count_o equals the number of low-ready cycles with valid high.
- out_ready_i=0, offer 3 ops (NUM_STAGES=2) -> first 2 accepted, in_ready_o=0 for the third until out_ready_i rises.
- Fill pipeline with 2 ops, assert kill_i one cycle while also offering an op -> offered op not accepted, out_valid_o=0 and busy_o=0 the next cycle; assert rst_ni low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/xif_copro_bitmanip_unit.sv
// xif_copro_bitmanip_unit
//   Pipelined bit-manipulation execution unit for the XIF coprocessor. The
//   result is computed combinationally from the operands and captured in
//   stage 0. Stages 1..NUM_STAGES-1 move data and tag forward unchanged. The
//   last stage drives the output.
//
//   Ports
//     clk_i, rst_ni              clock, asynchronous active-low reset
//     in_valid_i / in_ready_o    operation handshake
//     op_i                       0 NONE 1 BITREV 2 BSWAP 3 POPCNT 4 CLZ 5 CTZ 6 ROL 7 ROR
//     rs1_i, rs2_i               operands (rs2 only supplies the rotate amount)
//     id_i, rd_i, rd_is_copro_i  tag carried alongside the data
//     kill_i                     flush every in-flight entry
//     out_valid_o / out_ready_i  result handshake
//     out_data_o, out_id_o, out_rd_o, out_rd_is_copro_o   result and tag
//     busy_o                     some stage holds a valid entry
//     op_count_o, stall_count_o  retired / output-stall counters
//
//   Build option XIF_COPRO_BITMANIP_STATS_EN: when defined, the counters are
//   built. They saturate and are not cleared by kill. When undefined, both
//   counter ports are tied to 0.
module xif_copro_bitmanip_unit #(
  parameter int WIDTH      = 32,
  parameter int ID_WIDTH   = 4,
  parameter int NUM_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [2:0]          op_i,
  input  logic [WIDTH-1:0]    rs1_i,
  input  logic [WIDTH-1:0]    rs2_i,
  input  logic [ID_WIDTH-1:0] id_i,
  input  logic [4:0]          rd_i,
  input  logic                rd_is_copro_i,
  input  logic                kill_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [WIDTH-1:0]    out_data_o,
  output logic [ID_WIDTH-1:0] out_id_o,
  output logic [4:0]          out_rd_o,
  output logic                out_rd_is_copro_o,
  output logic                busy_o,
  output logic [31:0]         op_count_o,
  output logic [31:0]         stall_count_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int NB = WIDTH / 8;
  localparam int TW = ID_WIDTH + 6;

  // ---------------- compute ----------------
  logic [WIDTH-1:0]   res;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] rot;
  logic [SW-1:0]      amt;
  logic               unused_rs2;

  assign amt        = rs2_i[SW-1:0];
  assign unused_rs2 = ^rs2_i[WIDTH-1:SW];

  always_comb begin
    res = rs1_i;
    cnt = '0;
    rot = '0;
    case (op_i)
      3'd1: for (int i = 0; i < WIDTH; i++) res[i] = rs1_i[WIDTH-1-i];
      3'd2: for (int b = 0; b < NB; b++) res[8*b +: 8] = rs1_i[8*(NB-1-b) +: 8];
      3'd3: begin
        for (int i = 0; i < WIDTH; i++) cnt = cnt + CW'(rs1_i[i]);
        res = WIDTH'(cnt);
      end
      3'd4: begin
        // Scan upward so that the highest set bit wins.
        cnt = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) if (rs1_i[i]) cnt = CW'(WIDTH - 1 - i);
        res = WIDTH'(cnt);
      end
      3'd5: begin
        cnt = CW'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) if (rs1_i[i]) cnt = CW'(i);
        res = WIDTH'(cnt);
      end
      3'd6: begin
        rot = {rs1_i, rs1_i} << amt;
        res = rot[2*WIDTH-1:WIDTH];
      end
      3'd7: begin
        rot = {rs1_i, rs1_i} >> amt;
        res = rot[WIDTH-1:0];
      end
      default: res = rs1_i;
    endcase
  end

  // ---------------- elastic pipeline ----------------
  logic [NUM_STAGES-1:0]            vld_q;
  logic [NUM_STAGES-1:0]            load;
  logic [NUM_STAGES-1:0][WIDTH-1:0] data_q;
  logic [NUM_STAGES-1:0][TW-1:0]    tag_q;

  // Stage k is blocked only when it and every stage after it are full and the
  // output is not ready. This closed form avoids a ripple through each stage.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_load
    assign load[k] = ~(&vld_q[NUM_STAGES-1:k]) | out_ready_i;
  end

  assign in_ready_o = ~kill_i & load[0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      data_q <= '0;
      tag_q  <= '0;
    end else if (kill_i) begin
      vld_q <= '0;
    end else begin
      if (load[0]) begin
        vld_q[0] <= in_valid_i;
        if (in_valid_i) begin
          data_q[0] <= res;
          tag_q[0]  <= {id_i, rd_i, rd_is_copro_i};
        end
      end
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (load[k]) begin
          vld_q[k] <= vld_q[k-1];
          if (vld_q[k-1]) begin
            data_q[k] <= data_q[k-1];
            tag_q[k]  <= tag_q[k-1];
          end
        end
      end
    end
  end

  assign out_valid_o = vld_q[NUM_STAGES-1];
  assign out_data_o  = data_q[NUM_STAGES-1];
  assign {out_id_o, out_rd_o, out_rd_is_copro_o} = tag_q[NUM_STAGES-1];
  assign busy_o      = |vld_q;

  // ---------------- statistics ----------------
`ifdef XIF_COPRO_BITMANIP_STATS_EN
  logic [31:0] op_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (out_valid_o && out_ready_i && (op_cnt_q != '1))     op_cnt_q    <= op_cnt_q + 32'd1;
      if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign op_count_o    = op_cnt_q;
  assign stall_count_o = stall_cnt_q;
`else
  assign op_count_o    = '0;
  assign stall_count_o = '0;
`endif

endmodule

// File: tb/tb_xif_copro_bitmanip_unit.sv
// Bench for xif_copro_bitmanip_unit: directed literal cases followed by a
// randomized stream. A queue-based reference model checks the outputs every cycle.
module tb_xif_copro_bitmanip_unit;
  localparam int W   = 32;
  localparam int IDW = 4;
  localparam int NS  = 2;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           in_valid = 1'b0, in_ready;
  logic [2:0]     op = '0;
  logic [W-1:0]   rs1 = '0, rs2 = '0;
  logic [IDW-1:0] id = '0;
  logic [4:0]     rd = '0;
  logic           rdc = 1'b0, kill = 1'b0;
  logic           out_valid, out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic [4:0]     out_rd;
  logic           out_rdc, busy;
  logic [31:0]    op_count, stall_count;

  always #5 clk = ~clk;

  xif_copro_bitmanip_unit #(.WIDTH(W), .ID_WIDTH(IDW), .NUM_STAGES(NS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .rs1_i(rs1), .rs2_i(rs2), .id_i(id), .rd_i(rd), .rd_is_copro_i(rdc),
    .kill_i(kill), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_id_o(out_id), .out_rd_o(out_rd),
    .out_rd_is_copro_o(out_rdc), .busy_o(busy), .op_count_o(op_count),
    .stall_count_o(stall_count)
  );

  int n_chk = 0, n_fail = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference operations, written straight from the operation definitions.
  function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W-1:0] r;
    int n, s;
    r = a;
    n = 0;
    s = int'(b % W);
    case (o)
      3'd1: r = {<<{a}};
      3'd2: r = {<<8{a}};
      3'd3: r = W'($countones(a));
      3'd4: begin while (n < W && a[W-1-n] == 1'b0) n++; r = W'(n); end
      3'd5: begin while (n < W && a[n] == 1'b0) n++; r = W'(n); end
      3'd6: r = (s == 0) ? a : ((a << s) | (a >> (W - s)));
      3'd7: r = (s == 0) ? a : ((a >> s) | (a << (W - s)));
      default: r = a;
    endcase
    return r;
  endfunction

  typedef struct {
    logic [W-1:0]   data;
    logic [IDW-1:0] id;
    logic [4:0]     rd;
    logic           rdc;
    int             acc;
  } exp_t;

  exp_t           q[$];
  logic [IDW-1:0] ret_ids[$];
  int             m_ops = 0, m_stalls = 0;
  logic           p_stall = 1'b0;
  logic [W-1:0]   p_data;
  logic [IDW-1:0] p_id;
  logic [4:0]     p_rd;
  logic           p_rdc;

  always @(posedge clk) cyc++;

  // Model and compare process.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_id", out_id, 0);
      chk("rst_out_rd", {out_rd, out_rdc}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_counters", {op_count, stall_count}, 0);
      q.delete();
      m_ops = 0; m_stalls = 0; p_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, !kill && (q.size() < NS || out_ready));
      chk("busy", busy, q.size() != 0);
      if (p_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, p_data);
        chk("stall_tag", {out_id, out_rd, out_rdc}, {p_id, p_rd, p_rdc});
      end
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_valid", out_valid, 0);
        else begin
          chk("data", out_data, q[0].data);
          chk("tag", {out_id, out_rd, out_rdc}, {q[0].id, q[0].rd, q[0].rdc});
          chk("latency_min", (cyc - q[0].acc) >= NS, 1);
        end
      end
`ifdef XIF_COPRO_BITMANIP_STATS_EN
      chk("op_count", op_count, m_ops);
      chk("stall_count", stall_count, m_stalls);
`else
      chk("counters_tied", {op_count, stall_count}, 0);
`endif
      p_stall = out_valid && !out_ready;
      p_data = out_data; p_id = out_id; p_rd = out_rd; p_rdc = out_rdc;
      if (out_valid && out_ready) begin
        m_ops++;
        ret_ids.push_back(out_id);
        if (q.size() != 0) void'(q.pop_front());
      end
      if (out_valid && !out_ready) m_stalls++;
      if (kill) begin q.delete(); p_stall = 1'b0; end
      if (in_valid && in_ready)
        q.push_back('{ref_op(op, rs1, rs2), id, rd, rdc, cyc});
    end
  end

  task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [IDW-1:0] i);
    op = o; rs1 = a; rs2 = b; id = i; rd = 5'(i) + 5'd3; rdc = i[0];
  endtask

  // One op into an empty pipeline with out_ready high: exact latency check.
  task automatic do_one(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [IDW-1:0] i, input logic [W-1:0] e);
    chk({nm, "_model"}, ref_op(o, a, b), e);
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; drive(o, a, b, i);
    @(negedge clk); chk({nm, "_accept"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({nm, "_early"}, out_valid, 0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_data"}, out_data, e);
    chk({nm, "_id"}, out_id, i);
    chk({nm, "_rd"}, out_rd, 5'(i) + 5'd3);
  endtask

  initial begin
    int sent, t, acc_n;
    logic acc;
    logic [W-1:0] v;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do_one("bitrev", 3'd1, 32'h00000001, 32'h0, 4'd1, 32'h80000000);
    do_one("bswap",  3'd2, 32'h11223344, 32'h0, 4'd2, 32'h44332211);
    do_one("popcnt", 3'd3, 32'hF0F0F0F0, 32'h0, 4'd3, 32'd16);
    do_one("clz0",   3'd4, 32'h00000000, 32'h0, 4'd4, 32'd32);
    do_one("ctz",    3'd5, 32'h80000000, 32'h0, 4'd5, 32'd31);
    do_one("clz",    3'd4, 32'h00010000, 32'h0, 4'd6, 32'd15);
    do_one("ctz0",   3'd5, 32'h00000000, 32'h0, 4'd7, 32'd32);
    do_one("rol33",  3'd6, 32'h80000001, 32'd33, 4'd8, 32'h00000003);
    do_one("ror1",   3'd7, 32'h00000003, 32'd1, 4'd9, 32'h80000001);
    do_one("none",   3'd0, 32'hDEADBEEF, 32'h0, 4'd10, 32'hDEADBEEF);
    repeat (3) @(posedge clk);

    // Back-to-back stream of 8 ops, out_ready toggling every cycle.
    #1 ret_ids.delete(); sent = 0; t = 0;
    in_valid = 1'b1; out_ready = 1'b0; drive(3'($urandom), $urandom, $urandom, 4'd0);
    while ((sent < 8 || ret_ids.size() < 8) && t < 200) begin
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      out_ready = ~out_ready;
      if (sent < 8) begin
        if (acc) drive(3'($urandom), $urandom, $urandom, 4'(sent));
      end else in_valid = 1'b0;
      t++;
    end
    chk("stream_count", ret_ids.size(), 8);
    for (int i = 0; i < 8 && i < ret_ids.size(); i++) chk("stream_order", ret_ids[i], i);

    // Capacity with out_ready low.
    out_ready = 1'b0; in_valid = 1'b1; acc_n = 0;
    drive(3'd1, 32'h1, 32'h0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); if (in_valid && in_ready) acc_n++;
      @(posedge clk); #1 drive(3'd1, 32'h1, 32'h0, 4'(acc_n));
    end
    chk("capacity", acc_n, NS);
    @(negedge clk); chk("full_not_ready", in_ready, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk); chk("ready_rises", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Kill with a full pipeline and an op offered.
    #1 out_ready = 1'b0; in_valid = 1'b1; drive(3'd3, 32'hFF, 32'h0, 4'd1);
    repeat (2) @(posedge clk);
    #1 kill = 1'b1; drive(3'd3, 32'hF, 32'h0, 4'd3);
    @(negedge clk); chk("kill_in_ready", in_ready, 0);
    chk("kill_full", busy, 1);
    @(posedge clk); #1 kill = 1'b0; in_valid = 1'b0;
    chk("kill_out_valid", out_valid, 0);
    chk("kill_busy", busy, 0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset mid-stream.
    #1 in_valid = 1'b1; drive(3'd2, 32'hA5A5_0001, 32'h0, 4'd5);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_data", {out_data, out_id, out_rd, out_rdc}, 0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      case ($urandom_range(3))
        0: v = '0;
        1: v = W'(1) << $urandom_range(W - 1);
        2: v = '1;
        default: v = $urandom;
      endcase
      in_valid  = ($urandom_range(3) != 0);
      drive(3'($urandom), v, $urandom, 4'($urandom));
      out_ready = ($urandom_range(2) != 0);
      kill      = ($urandom_range(59) == 0);
      rst_n     = (i != 1500);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    repeat (6) @(posedge clk);
    chk("drained", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
